// File: rtl/memory_stage.sv
// MEM pipeline stage: forwards ALU results to writeback with one cycle of latency,
// and runs word loads/stores over a req/ack handshake, stalling upstream until done.
module memory_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_mem_oper,
    input  logic        ex_mem_readmem,
    input  logic        ex_mem_writemem,
    input  logic [4:0]  ex_mem_regdest,
    input  logic        ex_mem_writereg,
    input  logic [31:0] ex_mem_wbvalue,
    input  logic [31:0] ex_mem_regb,
    output logic        mem_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        mem_wb_oper,
    output logic [4:0]  mem_wb_regdest,
    output logic        mem_wb_writereg,
    output logic [31:0] mem_wb_wbvalue
);

    typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               error_q, error_d;
    logic               wb_oper_q, wb_oper_d;
    logic [4:0]         wb_regdest_q, wb_regdest_d;
    logic               wb_writereg_q, wb_writereg_d;
    logic [31:0]        wb_wbvalue_q, wb_wbvalue_d;
    logic [4:0]         lat_regdest_q, lat_regdest_d;
    logic               lat_writereg_q, lat_writereg_d;

    logic is_mem_op;
    logic waiting;
    logic timeout;
    logic done;

    assign is_mem_op = ex_mem_oper && (ex_mem_readmem || ex_mem_writemem);
    assign waiting   = (state_q != IDLE);
    // Ack takes priority: a timeout only fires when the final wait cycle has no ack.
    assign timeout   = waiting && (cnt_q == CNT_W'(TIMEOUT - 1)) && !mem_ack;
    assign done      = waiting && (mem_ack || timeout);

    // Stall is gated by reset so an in-flight access is released the moment reset hits.
    assign mem_stall = !reset && (waiting ? !done : is_mem_op);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        error_d        = error_q;
        wb_oper_d      = 1'b0;
        wb_regdest_d   = wb_regdest_q;
        wb_writereg_d  = wb_writereg_q;
        wb_wbvalue_d   = wb_wbvalue_q;
        lat_regdest_d  = lat_regdest_q;
        lat_writereg_d = lat_writereg_q;

        case (state_q)
            IDLE: begin
                if (is_mem_op) begin
                    lat_regdest_d  = ex_mem_regdest;
                    lat_writereg_d = ex_mem_writereg;
                    addr_d         = {ex_mem_wbvalue[31:2], 2'b00};
                    wdata_d        = ex_mem_regb;
                    we_d           = ex_mem_writemem;
                    req_d          = 1'b1;
                    cnt_d          = '0;
                    state_d        = ex_mem_writemem ? WAIT_WR : WAIT_RD;
                end else if (ex_mem_oper) begin
                    wb_oper_d     = 1'b1;
                    wb_regdest_d  = ex_mem_regdest;
                    wb_writereg_d = ex_mem_writereg;
                    wb_wbvalue_d  = ex_mem_wbvalue;
                end
            end
            WAIT_RD, WAIT_WR: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    req_d        = 1'b0;
                    cnt_d        = '0;
                    state_d      = IDLE;
                    wb_oper_d    = 1'b1;
                    wb_regdest_d = lat_regdest_q;
                    if (!mem_ack) begin
                        error_d       = 1'b1;
                        wb_writereg_d = 1'b0;
                    end else if (state_q == WAIT_RD) begin
                        wb_writereg_d = lat_writereg_q;
                        wb_wbvalue_d  = mem_rdata;
                    end else begin
                        wb_writereg_d = 1'b0;
                        wb_wbvalue_d  = addr_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            error_q        <= 1'b0;
            wb_oper_q      <= 1'b0;
            wb_regdest_q   <= '0;
            wb_writereg_q  <= 1'b0;
            wb_wbvalue_q   <= '0;
            lat_regdest_q  <= '0;
            lat_writereg_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            req_q          <= req_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            error_q        <= error_d;
            wb_oper_q      <= wb_oper_d;
            wb_regdest_q   <= wb_regdest_d;
            wb_writereg_q  <= wb_writereg_d;
            wb_wbvalue_q   <= wb_wbvalue_d;
            lat_regdest_q  <= lat_regdest_d;
            lat_writereg_q <= lat_writereg_d;
        end
    end

    assign mem_req         = req_q;
    assign mem_we          = we_q;
    assign mem_addr        = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_error       = error_q;
    assign mem_wb_oper     = wb_oper_q;
    assign mem_wb_regdest  = wb_regdest_q;
    assign mem_wb_writereg = wb_writereg_q;
    assign mem_wb_wbvalue  = wb_wbvalue_q;

endmodule
